// File: rtl/bram_byte_port.sv
// bram_byte_port: byte <-> bit-serial adapter for an 8192x1 dual-port BRAM.
// Bytes go out and come back LSB first; read bits are reassembled after RD_LAT.
module bram_byte_port #(
  parameter int ADDR_W  = 13,
  parameter int BYTE_AW = 10,
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  input  logic [BYTE_AW-1:0] wr_addr,
  input  logic [7:0]         wr_data,
  output logic               wr_ready,
  input  logic               rd_req,
  input  logic [BYTE_AW-1:0] rd_addr,
  output logic               rd_ready,
  output logic               rd_valid,
  output logic [7:0]         rd_data,
  output logic               busy,
  output logic               bram_di,
  output logic               bram_we,
  output logic               bram_wren,
  output logic [ADDR_W-1:0]  bram_wraddr,
  output logic               bram_rden,
  output logic [ADDR_W-1:0]  bram_rdaddr,
  output logic               bram_regce,
  input  logic               bram_do
);

  localparam int LAST = 7 + RD_LAT;
  localparam int CW   = $clog2(LAST + 1);
  localparam logic [CW-1:0] CAP0 = CW'(RD_LAT);
  localparam logic [CW-1:0] CEND = CW'(LAST);
  localparam logic [CW-1:0] WEND = CW'(7);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t              state_q, state_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [BYTE_AW-1:0]  addr_q, addr_n;
  logic [7:0]          sh_q, sh_n;
  logic [7:0]          rdat_n;
  logic [ADDR_W-1:0]   wa_n, ra_n;
  logic                we_n, di_n, rden_n, rv_n;
  logic                acc_wr, acc_rd;
  logic [2:0]          bnx;

  // wr_ready is only ever high in IDLE, so it doubles as the idle flag
  assign rd_ready   = wr_ready & ~wr_valid;
  assign acc_wr     = wr_valid & wr_ready;
  assign acc_rd     = rd_req & rd_ready;
  assign bnx        = 3'(cnt_q + 1'b1);
  assign bram_wren  = bram_we;
  assign bram_regce = 1'b1;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    addr_n  = addr_q;
    sh_n    = sh_q;
    rdat_n  = rd_data;
    wa_n    = bram_wraddr;
    ra_n    = bram_rdaddr;
    we_n    = 1'b0;
    di_n    = 1'b0;
    rden_n  = 1'b0;
    rv_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc_wr) begin
          state_n = WRITE;
          cnt_n   = '0;
          addr_n  = wr_addr;
          sh_n    = wr_data;
          we_n    = 1'b1;
          di_n    = wr_data[0];
          wa_n    = {wr_addr, 3'd0};
        end else if (acc_rd) begin
          state_n = READ;
          cnt_n   = '0;
          addr_n  = rd_addr;
          rden_n  = 1'b1;
          ra_n    = {rd_addr, 3'd0};
        end
      end
      WRITE: begin
        if (cnt_q == WEND) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
          we_n  = 1'b1;
          di_n  = sh_q[bnx];
          wa_n  = {addr_q, bnx};
        end
      end
      READ: begin
        cnt_n = cnt_q + 1'b1;
        if (cnt_q < WEND) begin
          rden_n = 1'b1;
          ra_n   = {addr_q, bnx};
        end
        // DO lags the issued address by RD_LAT cycles
        if (cnt_q >= CAP0) sh_n = {bram_do, sh_q[7:1]};
        if (cnt_q == CEND) begin
          state_n = DONE;
          rv_n    = 1'b1;
          rdat_n  = {bram_do, sh_q[7:1]};
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      sh_q        <= '0;
      wr_ready    <= 1'b0;
      busy        <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      bram_di     <= 1'b0;
      bram_we     <= 1'b0;
      bram_wraddr <= '0;
      bram_rden   <= 1'b0;
      bram_rdaddr <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      addr_q      <= addr_n;
      sh_q        <= sh_n;
      wr_ready    <= (state_n == IDLE);
      busy        <= (state_n != IDLE);
      rd_valid    <= rv_n;
      rd_data     <= rdat_n;
      bram_di     <= di_n;
      bram_we     <= we_n;
      bram_wraddr <= wa_n;
      bram_rden   <= rden_n;
      bram_rdaddr <= ra_n;
    end
  end

endmodule

// File: tb/tb_bram_byte_port.sv
// tb_bram_byte_port: BRAM behavioural model plus a byte-level timeline model
// checked against the DUT every cycle, with directed and random traffic.
module tb_bram_byte_port;

  localparam int AW  = 13;
  localparam int BW  = 10;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [BW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          rd_req = 1'b0;
  logic [BW-1:0] rd_addr = '0;
  logic          wr_ready, rd_ready, rd_valid, busy;
  logic [7:0]    rd_data;
  logic          bram_di, bram_we, bram_wren, bram_rden, bram_regce;
  logic [AW-1:0] bram_wraddr, bram_rdaddr;
  logic          bram_do;

  int nchk = 0;
  int nerr = 0;
  int cyc;

  always #5 clk = ~clk;

  bram_byte_port #(.ADDR_W(AW), .BYTE_AW(BW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .bram_di(bram_di), .bram_we(bram_we), .bram_wren(bram_wren),
    .bram_wraddr(bram_wraddr), .bram_rden(bram_rden),
    .bram_rdaddr(bram_rdaddr), .bram_regce(bram_regce),
    .bram_do(bram_do)
  );

  // 8192x1 BRAM with registered output: two-cycle read latency
  logic mem [0:8191];
  logic s1;
  always @(posedge clk) begin
    if (bram_we && bram_wren) mem[bram_wraddr] <= bram_di;
    if (bram_rden) s1 <= mem[bram_rdaddr];
    bram_do <= s1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  logic live;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) live <= 1'b0;
    else live <= 1'b1;

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // mode 0 idle, 1 write, 2 read; t counts cycles since the accept edge
  int            mode = 0;
  int            t0 = 0;
  logic [BW-1:0] ma;
  logic [7:0]    md;
  logic [7:0]    last_rd;
  logic [AW-1:0] ewa, era;
  logic [7:0]    ref_mem [0:1023];

  always @(negedge clk) begin : cmp
    int t, k;
    logic e_wr, e_rr, e_busy, e_we, e_di, e_rden, e_rv;
    e_we = 0; e_di = 0; e_rden = 0; e_rv = 0;
    if (!live) begin
      mode = 0; last_rd = '0; ewa = '0; era = '0;
      e_wr = 0; e_rr = 0; e_busy = 0;
    end else begin
      t = cyc - t0;
      if (mode == 1 && t >= 9) mode = 0;
      if (mode == 2 && t >= 12) mode = 0;
      if (mode == 1) begin
        k = t - 1;
        e_we = 1;
        e_di = md[k];
        ewa = {ma, 3'(k)};
        ref_mem[ma][k] = md[k];
      end
      if (mode == 2) begin
        if (t <= 8) begin
          e_rden = 1;
          era = {ma, 3'(t - 1)};
        end
        if (t == 11) begin
          e_rv = 1;
          last_rd = ref_mem[ma];
        end
      end
      e_wr = (mode == 0);
      e_busy = (mode != 0);
      e_rr = e_wr & ~wr_valid;
    end
    chk("wr_ready", 16'(wr_ready), 16'(e_wr));
    chk("rd_ready", 16'(rd_ready), 16'(e_rr));
    chk("busy", 16'(busy), 16'(e_busy));
    chk("bram_we", 16'(bram_we), 16'(e_we));
    chk("bram_wren", 16'(bram_wren), 16'(e_we));
    chk("bram_di", 16'(bram_di), 16'(e_di));
    chk("bram_wraddr", 16'(bram_wraddr), 16'(ewa));
    chk("bram_rden", 16'(bram_rden), 16'(e_rden));
    chk("bram_rdaddr", 16'(bram_rdaddr), 16'(era));
    chk("rd_valid", 16'(rd_valid), 16'(e_rv));
    chk("rd_data", 16'(rd_data), 16'(last_rd));
    chk("bram_regce", 16'(bram_regce), 16'd1);
    if (live && mode == 0) begin
      if (wr_valid) begin
        mode = 1; t0 = cyc; ma = wr_addr; md = wr_data;
      end else if (rd_req) begin
        mode = 2; t0 = cyc; ma = rd_addr;
      end
    end
  end

  task automatic do_write(input logic [BW-1:0] a, input logic [7:0] d,
                          input bit tr, input int base);
    bit ok = 0;
    @(posedge clk); #1;
    wr_valid = 1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (wr_ready) ok = 1;
      @(posedge clk); #1;
    end
    wr_valid = 0;
    if (!ok) begin
      nchk++; nerr++;
      $display("FAIL wr_accept: timeout want accept within 40 cycles");
    end else if (tr) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk("trace_wraddr", 16'(bram_wraddr), 16'(base + k));
        chk("trace_di", 16'(bram_di), 16'(d[k]));
        chk("trace_we", 16'(bram_we & bram_wren), 16'd1);
      end
      @(negedge clk);
      chk("wr_ready_c9", 16'(wr_ready), 16'd1);
    end
  endtask

  task automatic do_read(input logic [BW-1:0] a, input int base,
                         input bit tr, output logic [7:0] q);
    bit ok = 0;
    q = '0;
    @(posedge clk); #1;
    rd_req = 1; rd_addr = a;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (rd_ready) ok = 1;
      @(posedge clk); #1;
    end
    rd_req = 0;
    if (!ok) begin
      nchk++; nerr++;
      $display("FAIL rd_accept: timeout want accept within 40 cycles");
    end else begin
      for (int c = 1; c <= 11; c++) begin
        @(negedge clk);
        if (tr && c <= 8)
          chk("trace_rdaddr", 16'(bram_rdaddr), 16'(base + c - 1));
        if (c == 11) begin
          chk("rd_valid_c11", 16'(rd_valid), 16'd1);
          q = rd_data;
        end
      end
    end
  endtask

  function automatic logic [BW-1:0] pick();
    int r = $urandom_range(0, 9);
    if (r < 7) return BW'($urandom_range(0, 3));
    if (r == 7) return '1;
    return BW'($urandom);
  endfunction

  logic [7:0] q;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", 16'(wr_ready), 16'd0);
    chk("rst_rd_data", 16'(rd_data), 16'd0);
    chk("rst_regce", 16'(bram_regce), 16'd1);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rel_wr_ready_pre", 16'(wr_ready), 16'd0);
    @(posedge clk); #1;
    chk("rel_wr_ready", 16'(wr_ready), 16'd1);

    do_write(3, 8'hA5, 1, 24);
    do_read(3, 24, 1, q);
    chk("read_a5", 16'(q), 16'h00A5);

    @(posedge clk); #1;
    wr_valid = 1; wr_addr = 5; wr_data = 8'h3C;
    rd_req = 1; rd_addr = 5;
    @(negedge clk);
    chk("simul_rd_ready", 16'(rd_ready), 16'd0);
    chk("simul_wr_ready", 16'(wr_ready), 16'd1);
    @(posedge clk); #1;
    wr_valid = 0;
    @(negedge clk);
    chk("simul_busy", 16'(busy), 16'd1);
    do_read(5, 40, 1, q);
    chk("simul_read", 16'(q), 16'h003C);

    do_write(0, 8'h5A, 0, 0);
    do_write(10'd1023, 8'hFF, 1, 8184);
    do_read(10'd1023, 8184, 1, q);
    chk("wrap_read", 16'(q), 16'h00FF);
    do_read(0, 0, 1, q);
    chk("byte0_read", 16'(q), 16'h005A);

    do_write(7, 8'h00, 0, 0);
    do_write(7, 8'hFF, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_we", 16'(bram_we), 16'd0);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_wr_ready", 16'(wr_ready), 16'd0);
    @(posedge clk); #1;
    rst_n = 1;
    do_read(7, 56, 1, q);
    chk("partial_read", 16'(q), 16'h000F);

    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 299) != 0);
      wr_valid = ($urandom_range(0, 3) == 0);
      rd_req = ($urandom_range(0, 2) == 0);
      wr_addr = pick();
      rd_addr = pick();
      wr_data = 8'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1; wr_valid = 0; rd_req = 0;
    repeat (20) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
